// File: rtl/incline_filt_if.sv
// Sample-in / average-out bundle for the incline smoother.
// The master drives samples and clear; the slave returns the smoothed result.
interface incline_filt_if;
    logic        vld;
    logic [12:0] incline;
    logic        clr;
    logic [12:0] incline_avg;
    logic [9:0]  incline_sat;
    logic        avg_vld;
    logic        full;

    modport master (
        output vld, incline, clr,
        input  incline_avg, incline_sat, avg_vld, full
    );

    modport slave (
        input  vld, incline, clr,
        output incline_avg, incline_sat, avg_vld, full
    );
endinterface

// File: rtl/incline_filt.sv
// Moving-average smoother over the last 2^DEPTH_LOG2 signed incline samples.
// Produces a registered floor average plus a 10-bit saturated copy.
module incline_filt #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    incline_filt_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = 13 + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [12:0]            samp_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr_q, wptr_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic [DEPTH_LOG2:0]    fill_q, fill_d;
    logic                   full_q, full_d;
    logic [12:0]            avg_q, avg_d;
    logic [9:0]             sat_q, sat_d;
    logic                   avg_vld_q;

    logic signed [SW-1:0]   inc_ext, old_ext, shifted;

    always_comb begin
        inc_ext = {{DEPTH_LOG2{bus.incline[12]}}, bus.incline};
        old_ext = {{DEPTH_LOG2{samp_q[wptr_q][12]}}, samp_q[wptr_q]};
        sum_d   = sum_q + inc_ext - old_ext;
        shifted = sum_d >>> DEPTH_LOG2;
        avg_d   = shifted[12:0];
        // Clip: bits 12..9 must all agree for the value to fit in 10 signed bits.
        if (avg_d[12]) begin
            sat_d = (&avg_d[12:9]) ? avg_d[9:0] : 10'h200;
        end else begin
            sat_d = (|avg_d[12:9]) ? 10'h1FF : avg_d[9:0];
        end
        wptr_d = wptr_q + DEPTH_LOG2'(1);
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + (DEPTH_LOG2 + 1)'(1);
        full_d = full_q | (fill_d == FILL_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) samp_q[i] <= '0;
            wptr_q    <= '0;
            sum_q     <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            avg_q     <= '0;
            sat_q     <= '0;
            avg_vld_q <= 1'b0;
        end else if (bus.clr) begin
            // Clear dominates a coincident sample, which is dropped.
            for (int i = 0; i < DEPTH; i++) samp_q[i] <= '0;
            wptr_q    <= '0;
            sum_q     <= '0;
            fill_q    <= '0;
            full_q    <= 1'b0;
            avg_q     <= '0;
            sat_q     <= '0;
            avg_vld_q <= 1'b0;
        end else if (bus.vld) begin
            samp_q[wptr_q] <= bus.incline;
            wptr_q    <= wptr_d;
            sum_q     <= sum_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            avg_q     <= avg_d;
            sat_q     <= sat_d;
            avg_vld_q <= 1'b1;
        end else begin
            avg_vld_q <= 1'b0;
        end
    end

    assign bus.incline_avg = avg_q;
    assign bus.incline_sat = sat_q;
    assign bus.avg_vld     = avg_vld_q;
    assign bus.full        = full_q;
endmodule

// File: doc/incline_filt.md
# incline_filt

Moving-average smoother for the signed incline stream produced by the inertial interface. Accepts each `vld`-qualified 13-bit incline sample and keeps a circular buffer of the last 2^DEPTH_LOG2 samples with a running sum. Outputs a registered average plus a 10-bit saturated copy for the downstream assist/torque conditioning logic.

## Interface
- `DEPTH_LOG2`, default 3: log2 of window length; window = 8 samples by default; legal 1..5.
- `clk`  in  1: system clock, all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `vld`  in  1: single-cycle strobe; `incline` is valid this cycle.
- `incline`  in  13: signed two's-complement incline sample.
- `clr`  in  1: synchronous clear of window, sum and `full`.
- `incline_avg`  out  13: signed window average, registered.
- `incline_sat`  out  10: `incline_avg` clipped to [-512, 511], registered.
- `avg_vld`  out  1: one-cycle pulse; new `incline_avg`/`incline_sat` present.
- `full`  out  1: window has received ≥ 2^DEPTH_LOG2 samples since reset/clr.

## Operation
- Storage: 2^DEPTH_LOG2 × 13-bit sample buffer, write pointer `wptr` (DEPTH_LOG2 bits), signed running sum `sum` of 13+DEPTH_LOG2 bits, fill counter saturating at 2^DEPTH_LOG2.
- On `vld` (and not `clr`):
  - `new_sum = sum + sext(incline) - sext(buf[wptr])`.
  - `buf[wptr] <= incline`.
  - `wptr <= wptr + 1`, wrapping modulo 2^DEPTH_LOG2.
  - `sum <= new_sum`.
  - `incline_avg <= new_sum >>> DEPTH_LOG2`: arithmetic shift, floor toward −∞, low 13 bits. Cannot overflow.
  - `incline_sat <= clip(new_sum >>> DEPTH_LOG2)`.
  - `avg_vld <= 1`.
  - Fill counter increments. `full <= 1` on the sample that brings it to 2^DEPTH_LOG2.
- Pre-fill: empty entries hold 0, so the divisor is always the full window length. Early averages are attenuated by design; consumers qualify with `full` if needed.
- No `vld`: all state holds. `avg_vld <= 0`. Outputs keep their last values.
- `clr` (synchronous), in the cycle it is asserted:
  - All buffer entries, `sum`, `wptr`, fill counter, `full`, `incline_avg` and `incline_sat` go to 0.
  - `avg_vld <= 0`.
  - `clr` together with `vld`: `clr` wins and the sample is discarded.
- Once `full`, it stays set until `rst_n` or `clr`. The fill counter does not wrap.

## Timing
- Reset (async, `rst_n` low): `incline_avg` = 0, `incline_sat` = 0, `avg_vld` = 0, `full` = 0. `sum`, `wptr`, fill counter and all buffer entries = 0.
- Latency: `vld` high on edge N → `avg_vld` high and new outputs visible after edge N+1, for exactly one cycle.
- Back-to-back `vld` on consecutive cycles is supported. One sample is accepted per cycle with no stall, and `avg_vld` pulses each cycle.
- `full` rises in the same cycle as the `avg_vld` for the 2^DEPTH_LOG2-th sample.
- Reset asserted mid-stream clears everything immediately. The first `vld` after release is treated as sample 1.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold `rst_n` low with `vld` toggling, then release. Required: all outputs 0, no `avg_vld` while in reset.
- Fill: from reset, 8 × `vld` with `incline`=100, consecutive cycles.
  - `incline_avg` sequence: 12, 25, 37, 50, 62, 75, 87, 100.
  - `avg_vld` high on each of the 8 cycles.
  - `full` rises on the 8th result.
- Wrap/eviction: after the fill above, send `incline`=200 three times.
  - `incline_avg`: 112, 125, 137 (oldest 100s evicted).
  - `wptr` wraps with no glitch.
- Negative/rounding: from reset, one sample of −3 gives `incline_avg` = −1 (floor). After 8 × −3, `incline_avg` = −3 and `incline_sat` = −3.
- Saturation:
  - 8 × 4000 gives `incline_avg` = 4000, `incline_sat` = 511.
  - 8 × −4096 gives `incline_avg` = −4096, `incline_sat` = −512.
- Clear/conflict:
  - Mid-window, assert `clr` together with `vld`(500). Required: all outputs 0, `full` = 0, no `avg_vld`, sample dropped.
  - Next `vld`(80) gives `incline_avg` = 10.
